fetch_unit: RTL

- Instruction-fetch stage directly upstream of the main controller/datapath in the extended single-cycle MIPS core.
- Holds the PC and talks to instruction memory through a req/ready handshake that tolerates wait states.
- Presents one instruction at a time (`instr`, whose op/funct fields feed the controller).
- Computes the next PC from the controller's `pcsrc`/`jump` decisions when the core retires the current instruction.

---
 rtl/fetch_unit.sv | 59 +++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage that holds the PC, fetches over a req/ready handshake with wait states, and computes the next PC on retire
//   clk, reset                : core clock, synchronous active-high reset
//   pcsrc, jump, signimm      : controller branch/jump decision and immediate, used only on the retire edge
//   advance                   : core retires the presented instruction
//   imem_req/addr/ready/rdata : instruction memory handshake
//   instr, instr_valid        : presented instruction and its qualifier
//   pc, pcplus4, retired      : current PC, PC + 4, retired-instruction count
module fetch_unit #(
   parameter int WIDTH = 32,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pcsrc,
   input  logic             jump,
   input  logic [WIDTH-1:0] signimm,
   input  logic             advance,
   output logic             imem_req,
   output logic [WIDTH-1:0] imem_addr,
   input  logic             imem_ready,
   input  logic [WIDTH-1:0] imem_rdata,
   output logic [WIDTH-1:0] instr,
   output logic             instr_valid,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pcplus4,
   output logic [WIDTH-1:0] retired
);
   typedef enum logic {FETCH, HOLD} state_t;
   state_t           r_state;
   logic [WIDTH-1:0] r_pc, r_instr, r_retired, w_pcplus4, w_next_pc;
   assign w_pcplus4 = r_pc + WIDTH'(4);
   // jump outranks a taken branch
   assign w_next_pc = jump  ? {w_pcplus4[31:28], r_instr[25:0], 2'b00} :
                      pcsrc ? w_pcplus4 + (signimm << 2) : w_pcplus4;
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= FETCH;
         r_pc      <= RESET_PC;
         r_instr   <= '0;
         r_retired <= '0;
      end else if (r_state == FETCH) begin
         if (imem_ready) begin
            r_instr <= imem_rdata;
            r_state <= HOLD;
         end
      end else if (advance) begin
         r_pc      <= w_next_pc;
         r_retired <= r_retired + WIDTH'(1);
         r_state   <= FETCH;
      end
   end
   assign imem_req    = (r_state == FETCH);
   assign instr_valid = (r_state == HOLD);
   assign imem_addr   = r_pc;
   assign pc          = r_pc;
   assign pcplus4     = w_pcplus4;
   assign instr       = r_instr;
   assign retired     = r_retired;
endmodule
